// File: rtl/div_16bit_seq.sv
// Multi-cycle restoring divider: one quotient bit per cycle, unsigned or
// two's-complement operands, start/busy/done handshake.

module div_16bit_seq #(
    parameter int WIDTH = 16,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             ovfl
);

    // state | meaning
    // IDLE  | waiting for start
    // CALC  | shift-and-subtract, one quotient bit per cycle
    // FIX   | apply signs, load result registers (also the divide-by-zero path)
    // DONE  | done pulse; a new start is accepted here as in IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dq;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   dmag;
    logic [WIDTH-1:0] dend_raw;
    logic             sgn_mode;
    logic             sign_q;
    logic             sign_r;
    logic             dbz_pend;
    logic             ovf_pend;

    logic             accept;
    logic             last_iter;
    logic             divisor_zero;
    logic [WIDTH:0]   dvs_ext;
    logic [WIDTH:0]   dvs_mag;
    logic [WIDTH-1:0] dnd_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    assign accept       = start && (state == IDLE || state == DONE);
    assign last_iter    = (cnt == CW'(ITERS - 1));
    assign divisor_zero = (divisor == '0);

    // 17-bit magnitude so that -32768 becomes an exact +32768
    assign dvs_ext = {is_signed & divisor[WIDTH-1], divisor};
    assign dvs_mag = dvs_ext[WIDTH] ? (~dvs_ext + 1'b1) : dvs_ext;
    assign dnd_mag = (is_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;

    assign shifted = {rem[WIDTH-1:0], dq[WIDTH-1]};
    assign trial   = shifted - dmag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    // divide-by-zero skips CALC but still spends one cycle in FIX
                    state_next = divisor_zero ? FIX : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC:    state_next = last_iter ? FIX : CALC;
            FIX:     state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            CALC:    busy = 1'b1;
            FIX:     busy = ~dbz_pend;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            dq          <= '0;
            rem         <= '0;
            dmag        <= '0;
            dend_raw    <= '0;
            sgn_mode    <= 1'b0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dbz_pend    <= 1'b0;
            ovf_pend    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            ovfl        <= 1'b0;
        end else begin
            if (accept) begin
                cnt         <= '0;
                dq          <= dnd_mag;
                rem         <= '0;
                dmag        <= dvs_mag;
                dend_raw    <= dividend;
                sgn_mode    <= is_signed;
                sign_q      <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                sign_r      <= is_signed & dividend[WIDTH-1];
                dbz_pend    <= divisor_zero;
                ovf_pend    <= is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                               && (divisor == {WIDTH{1'b1}});
                div_by_zero <= 1'b0;
                ovfl        <= 1'b0;
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                if (!trial[WIDTH]) begin
                    rem <= trial;
                    dq  <= {dq[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= shifted;
                    dq  <= {dq[WIDTH-2:0], 1'b0};
                end
            end else if (state == FIX) begin
                if (dbz_pend) begin
                    quotient    <= {WIDTH{1'b1}};
                    remainder   <= dend_raw;
                    div_by_zero <= 1'b1;
                end else begin
                    quotient    <= (sgn_mode && sign_q) ? (~dq + 1'b1) : dq;
                    remainder   <= (sgn_mode && sign_r) ? (~rem[WIDTH-1:0] + 1'b1)
                                                        : rem[WIDTH-1:0];
                    ovfl        <= ovf_pend;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_16bit_seq.sv
// Directed bench for div_16bit_seq: hand-computed results, latency and
// busy profile, divide-by-zero, signed overflow, ignored start, reset abort.

module tb_div_16bit_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        ovfl;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_16bit_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .ovfl        (ovfl)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called #1 after an accepting edge; lat counts cycles so that done in the
    // cycle after edge k+17 gives lat = 18.
    task automatic wait_done(input int lat0, input int b0, output int lat, output int bcnt);
        lat  = lat0;
        bcnt = b0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        if (!done) check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic launch(input logic s, input logic [15:0] a, input logic [15:0] b);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        start     = 1'b0;
        dividend  = 16'h5A5A;
        divisor   = 16'h0003;
        is_signed = ~s;
    endtask

    task automatic run_op(input string tag, input logic s, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] eq, input logic [15:0] er,
                          input logic edz, input logic eov, input int elat, input int ebusy);
        int lat, bc;
        launch(s, a, b);
        wait_done(1, busy ? 1 : 0, lat, bc);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_busy"}, bc, ebusy);
        check({tag, "_q"}, {16'd0, quotient}, {16'd0, eq});
        check({tag, "_r"}, {16'd0, remainder}, {16'd0, er});
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edz});
        check({tag, "_ovfl"}, {31'd0, ovfl}, {31'd0, eov});
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat, bc, seen;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q", {16'd0, quotient}, 32'd0);
        check("rst_r", {16'd0, remainder}, 32'd0);
        check("rst_flags", {30'd0, div_by_zero, ovfl}, 32'd0);

        run_op("u100_7",   1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 18, 17);
        run_op("s-7_2",    1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 18, 17);
        run_op("s7_-2",    1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 18, 17);
        run_op("dbz",      1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 2, 0);
        run_op("s_ovf",    1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 18, 17);
        run_op("uFFFF_1",  1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 18, 17);
        run_op("u8000_FF", 1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 18, 17);
        run_op("s-32768_2",1'b1, 16'h8000, 16'h0002, 16'hC000, 16'h0000, 1'b0, 1'b0, 18, 17);
        run_op("s-100_-7", 1'b1, 16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0, 18, 17);
        run_op("s_dbz",    1'b1, 16'h8001, 16'h0000, 16'hFFFF, 16'h8001, 1'b1, 1'b0, 2, 0);

        // second start while busy must be ignored
        launch(1'b0, 16'd1000, 16'd10);
        lat = 1; bc = 1;
        repeat (4) begin
            @(posedge clk); #1; lat++; if (busy) bc++;
        end
        start = 1'b1; dividend = 16'd50; divisor = 16'd5;
        @(posedge clk); #1; lat++; if (busy) bc++;
        start = 1'b0;
        wait_done(lat, bc, lat, bc);
        check("ign_lat", lat, 18);
        check("ign_q", {16'd0, quotient}, 32'd100);
        check("ign_r", {16'd0, remainder}, 32'd0);
        @(posedge clk); #1;
        check("ign_no_second", {31'd0, done | busy}, 32'd0);

        // reset mid-operation aborts with no done pulse
        launch(1'b0, 16'd100, 16'd7);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_q", {16'd0, quotient}, 32'd0);
        check("abort_r", {16'd0, remainder}, 32'd0);
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check("abort_quiet", seen, 0);

        // start held through the done cycle launches a second op
        start = 1'b1; is_signed = 1'b0; dividend = 16'd100; divisor = 16'd7;
        @(posedge clk); #1;
        dividend = 16'd200; divisor = 16'd9;
        wait_done(1, 1, lat, bc);
        check("held1_lat", lat, 18);
        check("held1_q", {16'd0, quotient}, 32'd14);
        check("held1_r", {16'd0, remainder}, 32'd2);
        @(posedge clk); #1;
        start = 1'b0;
        check("held2_busy", {31'd0, busy}, 32'd1);
        wait_done(1, 1, lat, bc);
        check("held2_lat", lat, 18);
        check("held2_q", {16'd0, quotient}, 32'd22);
        check("held2_r", {16'd0, remainder}, 32'd2);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
